// File: rtl/i2c_slave_byte_ctrl.sv
// I2C target byte engine: synchronizes raw SCL/SDA, detects START/STOP, matches a
// 7-bit address, ACKs/NACKs, and moves payload bytes over rx/tx valid/ready ports.
module i2c_slave_byte_ctrl #(
  parameter int              ALEN     = 7,
  parameter logic [ALEN-1:0] SLV_ADDR = 7'h50
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_vld,
  output logic       tx_ready,
  output logic       start_det,
  output logic       stop_det,
  output logic       addr_match,
  output logic       tx_underrun,
  output logic [2:0] curr_status
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;

  logic scl_s1_q, scl_s2_q, scl_d_q;
  logic sda_s1_q, sda_s2_q, sda_d_q;
  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;
  logic       nack_q, nack_d;
  logic       oe_q, oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_vld_q, rx_vld_d;
  logic       tx_ready_q, tx_ready_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       match_q, match_d;
  logic       under_q, under_d;

  logic scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] load_byte;

  assign scl_rise  = scl_s2_q & ~scl_d_q;
  assign scl_fall  = ~scl_s2_q & scl_d_q;
  // SDA edges only count as START/STOP while SCL is stable high across both samples.
  assign start_c   = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
  assign stop_c    = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;
  assign load_byte = tx_vld ? tx_data : 8'hFF;

  // rx: rx_vld holds rx_data until the cycle with rx_vld && rx_ready, then clears.
  // tx: tx_data is taken when a read byte is loaded while tx_vld=1; tx_ready pulses then.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    nack_d     = nack_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_vld_d   = rx_vld_q;
    tx_ready_d = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    match_d    = 1'b0;
    under_d    = 1'b0;
    if (rx_vld_q && rx_ready) rx_vld_d = 1'b0;
    if (start_c) begin
      start_d   = 1'b1;
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
    end else if (stop_c) begin
      stop_d  = 1'b1;
      state_d = S_IDLE;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s2_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_d[7:1] == SLV_ADDR) begin
              state_d = S_ADDR_ACK;
              rw_d    = shift_d[0];
              phase_d = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            oe_d    = 1'b1;
            match_d = 1'b1;
            phase_d = 1'b1;
          end else if (!rw_q) begin
            oe_d      = 1'b0;
            state_d   = S_WR_BYTE;
            bit_cnt_d = 3'd0;
          end else begin
            shift_d    = load_byte;
            oe_d       = ~load_byte[7];
            tx_ready_d = tx_vld;
            under_d    = ~tx_vld;
            state_d    = S_RD_BYTE;
            bit_cnt_d  = 3'd0;
          end
        end
        S_WR_BYTE: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s2_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d = shift_d;
            rx_vld_d  = 1'b1;
            state_d   = S_WR_ACK;
            phase_d   = 1'b0;
            nack_d    = 1'b0;
          end
        end
        S_WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            // A byte the user has not taken by now is dropped and NACKed.
            if (!rx_vld_q || rx_ready) begin
              oe_d = 1'b1;
            end else begin
              oe_d     = 1'b0;
              rx_vld_d = 1'b0;
              nack_d   = 1'b1;
            end
          end else begin
            oe_d    = 1'b0;
            state_d = nack_q ? S_IDLE : S_WR_BYTE;
          end
        end
        S_RD_BYTE: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            oe_d      = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = S_RD_ACK;
            phase_d   = 1'b0;
          end else begin
            shift_d   = {shift_q[6:0], 1'b1};
            oe_d      = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s2_q) state_d = S_IDLE;
            else          phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            shift_d    = load_byte;
            oe_d       = ~load_byte[7];
            tx_ready_d = tx_vld;
            under_d    = ~tx_vld;
            state_d    = S_RD_BYTE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_d_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_d_q    <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      nack_q     <= 1'b0;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_vld_q   <= 1'b0;
      tx_ready_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      match_q    <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_d_q    <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_d_q    <= sda_s2_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      nack_q     <= nack_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
      tx_ready_q <= tx_ready_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      match_q    <= match_d;
      under_q    <= under_d;
    end
  end

  assign sda_oe      = oe_q;
  assign rx_data     = rx_data_q;
  assign rx_vld      = rx_vld_q;
  assign tx_ready    = tx_ready_q;
  assign start_det   = start_q;
  assign stop_det    = stop_q;
  assign addr_match  = match_q;
  assign tx_underrun = under_q;
  assign curr_status = state_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Directed bench for i2c_slave_byte_ctrl: a bit-level I2C master on an open-drain
// SDA line, event counters, and an expected-byte queue for rx and tx data.
module tb_i2c_slave_byte_ctrl;
  localparam int Q = 10;

  logic       clock = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  wire        sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_vld, rx_ready;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_ready, start_det, stop_det, addr_match, tx_underrun;
  logic [2:0] curr_status;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0, n_stop = 0, n_match = 0, n_txr = 0, n_under = 0;
  int n_rx = 0, n_oe = 0, n_vld_rise = 0;
  logic [7:0] last_rx = 8'd0;
  logic       vld_prev = 1'b0;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_byte_ctrl dut (
    .clock(clock), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_ready(tx_ready),
    .start_det(start_det), .stop_det(stop_det), .addr_match(addr_match),
    .tx_underrun(tx_underrun), .curr_status(curr_status)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    repeat (60000) @(posedge clock);
    $display("FAIL watchdog: observed no finish, expected finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clock) begin
    if (start_det)   n_start++;
    if (stop_det)    n_stop++;
    if (addr_match)  n_match++;
    if (tx_ready)    n_txr++;
    if (tx_underrun) n_under++;
    if (sda_oe)      n_oe++;
    if (rx_vld && !vld_prev) n_vld_rise++;
    vld_prev = rx_vld;
    if (rx_vld && rx_ready) begin
      n_rx++;
      last_rx = rx_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wait_q();
    repeat (Q) @(negedge clock);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_bus;  wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  task automatic check_pop(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(obs), 32'(e));
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int b_start, b_stop, b_match, b_txr, b_under, b_rx, b_oe, b_vr;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    rx_ready = 1'b1; tx_vld = 1'b0; tx_data = 8'h00;
    repeat (4) @(negedge clock);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_status", 32'(curr_status), 32'd0);
    check("rst_rx_vld", 32'(rx_vld), 32'd0);
    check("rst_pulses", 32'({tx_ready, start_det, stop_det, addr_match, tx_underrun}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clock);

    // 1: write two bytes with rx_ready high
    b_start = n_start; b_stop = n_stop; b_match = n_match; b_rx = n_rx;
    i2c_start();
    write_byte(8'hA0, ack);   check("t1_addr_ack", 32'(ack), 32'd0);
    exp_q.push_back(8'h3C);
    write_byte(8'h3C, ack);   check("t1_d0_ack", 32'(ack), 32'd0);
    check_pop("t1_rx0", last_rx);
    exp_q.push_back(8'hC3);
    write_byte(8'hC3, ack);   check("t1_d1_ack", 32'(ack), 32'd0);
    check_pop("t1_rx1", last_rx);
    i2c_stop();
    check("t1_rx_count", 32'(n_rx - b_rx), 32'd2);
    check("t1_start", 32'(n_start - b_start), 32'd1);
    check("t1_match", 32'(n_match - b_match), 32'd1);
    check("t1_stop", 32'(n_stop - b_stop), 32'd1);
    check("t1_status", 32'(curr_status), 32'd0);

    // 2: foreign address 0x51
    b_oe = n_oe; b_rx = n_rx; b_vr = n_vld_rise; b_match = n_match;
    i2c_start();
    write_byte(8'hA2, ack);   check("t2_addr_nack", 32'(ack), 32'd1);
    check("t2_status_mid", 32'(curr_status), 32'd0);
    write_byte(8'h55, ack);   check("t2_data_nack", 32'(ack), 32'd1);
    i2c_stop();
    check("t2_oe_cycles", 32'(n_oe - b_oe), 32'd0);
    check("t2_rx_vld", 32'(n_vld_rise - b_vr), 32'd0);
    check("t2_match", 32'(n_match - b_match), 32'd0);
    check("t2_status", 32'(curr_status), 32'd0);

    // 3: read two bytes, master ACK then NACK
    b_txr = n_txr; b_under = n_under;
    tx_vld = 1'b1; tx_data = 8'h96;
    exp_q.push_back(8'h96);
    i2c_start();
    write_byte(8'hA1, ack);   check("t3_addr_ack", 32'(ack), 32'd0);
    read_byte(rd);            check_pop("t3_rd0", rd);
    tx_data = 8'h5A;
    exp_q.push_back(8'h5A);
    write_bit(1'b0);
    read_byte(rd);            check_pop("t3_rd1", rd);
    write_bit(1'b1);
    check("t3_status_nack", 32'(curr_status), 32'd0);
    i2c_stop();
    tx_vld = 1'b0;
    check("t3_tx_ready", 32'(n_txr - b_txr), 32'd2);
    check("t3_underrun", 32'(n_under - b_under), 32'd0);

    // 4: user not ready, data byte NACKed and dropped
    rx_ready = 1'b0;
    b_vr = n_vld_rise; b_rx = n_rx;
    i2c_start();
    write_byte(8'hA0, ack);   check("t4_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h11, ack);   check("t4_data_nack", 32'(ack), 32'd1);
    check("t4_rx_vld_low", 32'(rx_vld), 32'd0);
    check("t4_vld_seen", 32'(n_vld_rise - b_vr), 32'd1);
    check("t4_status", 32'(curr_status), 32'd0);
    i2c_stop();
    check("t4_rx_count", 32'(n_rx - b_rx), 32'd0);
    rx_ready = 1'b1;

    // 5: write, repeated START, read with no tx data
    b_start = n_start; b_txr = n_txr; b_under = n_under;
    i2c_start();
    write_byte(8'hA0, ack);   check("t5_addr_ack", 32'(ack), 32'd0);
    exp_q.push_back(8'h01);
    write_byte(8'h01, ack);   check("t5_d0_ack", 32'(ack), 32'd0);
    check_pop("t5_rx0", last_rx);
    i2c_start();
    check("t5_status_rs", 32'(curr_status), 32'd1);
    write_byte(8'hA1, ack);   check("t5_raddr_ack", 32'(ack), 32'd0);
    exp_q.push_back(8'hFF);
    read_byte(rd);            check_pop("t5_rd_ff", rd);
    write_bit(1'b1);
    i2c_stop();
    check("t5_start", 32'(n_start - b_start), 32'd2);
    check("t5_underrun", 32'(n_under - b_under), 32'd1);
    check("t5_tx_ready", 32'(n_txr - b_txr), 32'd0);

    // 6: reset while ACK is driven, then a normal frame
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(((8'hA0 >> i) & 8'h01) != 8'h00);
    sda_m = 1'b1; wait_q();
    check("t6_oe_before", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    @(negedge clock);
    check("t6_oe_after", 32'(sda_oe), 32'd0);
    check("t6_status_rst", 32'(curr_status), 32'd0);
    rst = 1'b0;
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
    check("t6_status_idle", 32'(curr_status), 32'd0);
    i2c_stop();
    b_rx = n_rx;
    i2c_start();
    write_byte(8'hA0, ack);   check("t6_addr_ack", 32'(ack), 32'd0);
    exp_q.push_back(8'h7E);
    write_byte(8'h7E, ack);   check("t6_d0_ack", 32'(ack), 32'd0);
    check_pop("t6_rx0", last_rx);
    i2c_stop();
    check("t6_rx_count", 32'(n_rx - b_rx), 32'd1);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
